bist_host: RTL and testbench
============================

# bist_host

Host-side sequencer for the TAP BIST engine: it drives the engine's load and run interface, which the engine otherwise receives from the TAP controller. It accepts a stream of test steps on a valid/ready port and writes each one into the engine's config/check memories with a GETTEST update. It then starts RUNBIST, waits for the engine's stop indication, and reports pass/fail together with the failing step index. It sits between a test-program source (CPU or ROM sequencer) and the BIST engine, with the engine's `clk` and `TCK` both tied to this block's `clk`.

## Interface

Parameters:
- `MAX_STEPS`, 256: engine memory depth; the load phase ends automatically after this many steps.
- `RUN_TIMEOUT`, 1024: clk cycles allowed in the run phase before a timeout is declared.

Ports:
- `clk` in 1: single clock for this block and for the engine (`clk` and `TCK`).
- `TLR` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to begin a program; honoured only in IDLE.
- `abort` in 1: terminates any active program.
- `cmd_valid` in 1: a test step is present.
- `cmd_ready` out 1: the block accepts a step this cycle.
- `cmd_cfg` in 5: stimulus word for the step.
- `cmd_chk` in 5: expected response in `[4:1]`; `[0]` is the stop flag.
- `cmd_last` in 1: marks the final step of the program.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: result, valid from `done` until the next `start`.
- `timeout` out 1: the run phase exceeded `RUN_TIMEOUT`.
- `fail_step` out 16: captured engine `BIST_DATA` on failure, 16'hFFFF on pass or timeout.
- `bist_tlr` out 1: reset to the engine.
- `bsr` out 10: `{cmd_cfg, cmd_chk}` presented to the engine.
- `updatedr` out 1: write strobe to the engine.
- `gettest_select` out 1: selects the engine's load path.
- `runbist_select` out 1: selects the engine's run path.
- `reset_sm` in 1: engine stop indication.
- `bist_error` in 1: engine error flag.
- `bist_data` in 16: engine result word.

## Operation

States are IDLE, CLEAR, LOAD, UPD, GAP, RUN, SETTLE and REPORT.

- **IDLE**
  - All strobes low; `cmd_ready`=0.
  - `start` moves to CLEAR and clears `pass`, `timeout`, the step counter and the timer.
- **CLEAR**
  - `bist_tlr`=1 for exactly 1 cycle, then LOAD.
- **LOAD**
  - `gettest_select`=1 and `cmd_ready`=1.
  - On `cmd_valid`: register `bsr` ← `{cmd_cfg, cmd_chk}`, latch `cmd_last`, then go to UPD.
- **UPD**
  - `gettest_select`=1, `updatedr`=1 for 1 cycle, `bsr` held stable; step counter +1.
  - If latched last, or counter == `MAX_STEPS`, go to GAP; otherwise return to LOAD.
  - `cmd_ready`=0, so at most one step is accepted every 2 cycles.
- **GAP**
  - All selects low for 1 cycle, which returns the engine's load pointer to 0. Then RUN.
- **RUN**
  - `runbist_select`=1; timer +1 each cycle.
  - `reset_sm`=1 moves to SETTLE.
  - Timer == `RUN_TIMEOUT`-1 with `reset_sm`=0 sets `timeout` and moves to REPORT.
- **SETTLE**
  - `runbist_select` stays 1 for 1 cycle so `bist_error` and `bist_data` settle, then REPORT.
- **REPORT**
  - `pass` = !`timeout` & !`bist_error` & (`bist_data` == 16'hFFFF).
  - `fail_step` = (`pass` | `timeout`) ? 16'hFFFF : `bist_data`.
  - `done`=1, `runbist_select`=0, then IDLE.

Abort and other rules:
- `abort` in any state other than IDLE/REPORT goes to REPORT with `pass`=0, `timeout`=0 and `fail_step`=16'hFFFF, then pulses `bist_tlr` in the following IDLE cycle.
- `abort` and `start` together in IDLE: `start` is ignored.
- `start` while busy is ignored.
- The step counter is `clog2(MAX_STEPS)+1` bits wide, so it never wraps.
- The timer saturates and never wraps.

## Timing

- **Reset**: `TLR` in any state goes to IDLE. All outputs return to 0, except `fail_step`=16'hFFFF and `bist_tlr`=1 for the reset cycle.
- **Output registers**: all outputs are registered and change only on the `clk` rising edge.
- **Start latency**: `start` at edge N gives `bist_tlr`=1 in cycle N+1 and `cmd_ready`=1 in cycle N+2.
- **Step handshake**: a step is accepted on the cycle where `cmd_valid` & `cmd_ready`. `updatedr` is high in the next cycle, with `bsr` unchanged from acceptance through the `updatedr` cycle.
- **Run entry**: `runbist_select` rises 2 cycles after the last `updatedr` (the GAP cycle, then RUN).
- **Completion**: `done` occurs exactly 2 cycles after the first cycle `reset_sm` is sampled high.

## Test plan

1. **Three-step pass**: load 3 steps whose checks match a loop-back model of the engine, last step with `chk[0]`=1 → three `updatedr` pulses with the correct `bsr` values, then `done` with `pass`=1 and `fail_step`=16'hFFFF.
2. **Mismatch at step 2**: the model returns a wrong response at step 2 and reports `bist_error`=1, `bist_data`=2 → `pass`=0, `fail_step`=16'h0002.
3. **Timeout**: `RUN_TIMEOUT`=16 with `reset_sm` held low → `done` after 16 RUN cycles plus REPORT, `timeout`=1, `pass`=0.
4. **Auto-stop at depth**: `MAX_STEPS`=4, send 6 steps with no `cmd_last` → exactly 4 `updatedr` pulses, `cmd_ready` stays low after the 4th, and RUN starts.
5. **Back-pressure**: `cmd_valid` toggles randomly → no step lost or duplicated, and `bsr` stays stable while `updatedr` is high.
6. **Reset and abort**: `TLR` during RUN → next cycle IDLE with all outputs at reset values. `abort` during LOAD → `done` with `pass`=0, followed by a `bist_tlr` pulse.

Source files
------------

// File: rtl/bist_host.sv
// bist_host: host-side sequencer for the TAP BIST engine.
// Streams test steps into the engine with GETTEST updates, runs RUNBIST,
// waits for the engine stop indication and reports pass/fail.
module bist_host #(
  parameter int MAX_STEPS   = 256,
  parameter int RUN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        TLR,
  input  logic        start,
  input  logic        abort,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_cfg,
  input  logic [4:0]  cmd_chk,
  input  logic        cmd_last,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] fail_step,
  output logic        bist_tlr,
  output logic [9:0]  bsr,
  output logic        updatedr,
  output logic        gettest_select,
  output logic        runbist_select,
  input  logic        reset_sm,
  input  logic        bist_error,
  input  logic [15:0] bist_data
);

  localparam int CW = $clog2(MAX_STEPS) + 1;
  localparam int TW = $clog2(RUN_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, UPD, GAP, RUN, SETTLE, REPORT
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      bsr_q, bsr_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic [15:0]     fail_step_q, fail_step_d;
  logic            aborted_q, aborted_d;
  logic            busy_q, busy_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            done_q, done_d;
  logic            gettest_q, gettest_d;
  logic            runbist_q, runbist_d;
  logic            updatedr_q, updatedr_d;
  logic            bist_tlr_q, bist_tlr_d;
  logic            pass_now;

  // Next-state, datapath updates and next values of the registered strobes.
  // Strobes decode the next state so they line up with state_q after the edge.
  always_comb begin
    state_d     = state_q;
    bsr_d       = bsr_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_step_d = fail_step_q;
    aborted_d   = aborted_q;
    pass_now    = !timeout_q && !bist_error && (bist_data == 16'hFFFF);

    if (abort && state_q != IDLE && state_q != REPORT) begin
      state_d     = REPORT;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_step_d = '1;
      aborted_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d   = CLEAR;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            cnt_d     = '0;
            tmr_d     = '0;
            aborted_d = 1'b0;
          end
        end
        CLEAR: state_d = LOAD;
        LOAD: begin
          if (cmd_valid) begin
            bsr_d   = {cmd_cfg, cmd_chk};
            last_d  = cmd_last;
            state_d = UPD;
          end
        end
        UPD: begin
          cnt_d = cnt_q + CW'(1);
          if (last_q || cnt_q == CW'(MAX_STEPS - 1)) state_d = GAP;
          else                                       state_d = LOAD;
        end
        GAP: state_d = RUN;
        RUN: begin
          if (tmr_q != '1) tmr_d = tmr_q + TW'(1);
          if (reset_sm) begin
            state_d = SETTLE;
          end else if (tmr_q == TW'(RUN_TIMEOUT - 1)) begin
            state_d     = REPORT;
            timeout_d   = 1'b1;
            pass_d      = 1'b0;
            fail_step_d = '1;
          end
        end
        SETTLE: begin
          state_d     = REPORT;
          pass_d      = pass_now;
          fail_step_d = pass_now ? 16'hFFFF : bist_data;
        end
        REPORT: begin
          state_d   = IDLE;
          aborted_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == LOAD);
    gettest_d   = (state_d == LOAD) || (state_d == UPD);
    updatedr_d  = (state_d == UPD);
    runbist_d   = (state_d == RUN) || (state_d == SETTLE);
    done_d      = (state_d == REPORT);
    // Engine reset on program start, and in the IDLE cycle that follows an abort.
    bist_tlr_d  = (state_d == CLEAR) || (state_q == REPORT && aborted_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (TLR) begin
      state_q     <= IDLE;
      bsr_q       <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_step_q <= '1;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      gettest_q   <= 1'b0;
      runbist_q   <= 1'b0;
      updatedr_q  <= 1'b0;
      bist_tlr_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      bsr_q       <= bsr_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_step_q <= fail_step_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      gettest_q   <= gettest_d;
      runbist_q   <= runbist_d;
      updatedr_q  <= updatedr_d;
      bist_tlr_q  <= bist_tlr_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign fail_step      = fail_step_q;
  assign bist_tlr       = bist_tlr_q;
  assign bsr            = bsr_q;
  assign updatedr       = updatedr_q;
  assign gettest_select = gettest_q;
  assign runbist_select = runbist_q;

endmodule

// File: tb/tb_bist_host.sv
// Testbench for bist_host: random programs against a step-level engine model.
module tb_bist_host;

  localparam int MS = 4;
  localparam int RT = 16;

  logic        clk = 1'b0;
  logic        TLR, start, abort, cmd_valid, cmd_last;
  logic [4:0]  cmd_cfg, cmd_chk;
  logic        reset_sm, bist_error;
  logic [15:0] bist_data;
  logic        cmd_ready, busy, done, pass, timeout;
  logic [15:0] fail_step;
  logic        bist_tlr, updatedr, gettest_select, runbist_select;
  logic [9:0]  bsr;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bist_host #(.MAX_STEPS(MS), .RUN_TIMEOUT(RT)) dut (
    .clk(clk), .TLR(TLR), .start(start), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cfg(cmd_cfg),
    .cmd_chk(cmd_chk), .cmd_last(cmd_last), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .fail_step(fail_step),
    .bist_tlr(bist_tlr), .bsr(bsr), .updatedr(updatedr),
    .gettest_select(gettest_select), .runbist_select(runbist_select),
    .reset_sm(reset_sm), .bist_error(bist_error), .bist_data(bist_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_engine();
    reset_sm   = 1'b0;
    bist_error = 1'b0;
    bist_data  = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pass"}, pass, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_fail_step"}, fail_step, 16'hFFFF);
    check_eq({tag, "_bist_tlr"}, bist_tlr, 1);
    check_eq({tag, "_bsr"}, bsr, 0);
    check_eq({tag, "_strobes"}, {cmd_ready, updatedr, gettest_select, runbist_select}, 0);
  endtask

  // One program: n steps offered, optional cmd_last on the final one,
  // step 'bad' gets a wrong expected response, 'hang' keeps the engine from stopping.
  task automatic run_prog(input int n, input bit use_last, input int bad, input bit hang, input int vpct);
    logic [4:0] pc[$];
    logic [4:0] pk[$];
    logic [4:0] c, k;
    int exp_n, stop_idx, fail_idx;
    bit stops, ready_late, exp_pass;
    int acc, upd, last_upd_cyc, run_cyc, rs_cyc, done_cyc;

    for (int i = 0; i < n; i++) begin
      c = 5'($urandom);
      k = {c[3:0], (use_last && i == n - 1)};
      if (i == bad) k[4:1] = ~c[3:0];
      pc.push_back(c);
      pk.push_back(k);
    end
    exp_n = (use_last && n <= MS) ? n : MS;

    // Engine behaviour: walks the loaded steps in order, stops at the first
    // response mismatch (error, index) or at the first step carrying the stop flag.
    stops = 1'b0; fail_idx = -1; stop_idx = 0;
    if (!hang) begin
      for (int i = 0; i < exp_n; i++) begin
        if (pk[i][4:1] != pc[i][3:0]) begin
          stops = 1'b1; fail_idx = i; stop_idx = i;
          break;
        end
        if (pk[i][0]) begin
          stops = 1'b1; stop_idx = i;
          break;
        end
      end
    end
    exp_pass = stops && (fail_idx < 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_tlr", bist_tlr, 1);
    check_eq("start_busy", busy, 1);
    check_eq("start_ready_lat", cmd_ready, 0);
    check_eq("start_clr_pass", {pass, timeout}, 0);
    step();
    check_eq("load_ready", {cmd_ready, gettest_select, bist_tlr}, 3'b110);

    acc = 0; upd = 0; last_upd_cyc = -100; run_cyc = -1; rs_cyc = -1; done_cyc = -1;
    ready_late = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (updatedr) begin
        check_eq("upd_gettest", gettest_select, 1);
        if (upd < exp_n) check_eq("upd_bsr", bsr, {pc[upd], pk[upd]});
        else             check_eq("upd_extra", upd + 1, exp_n);
        upd++;
        last_upd_cyc = cyc;
      end
      if (upd >= exp_n && cmd_ready) ready_late = 1'b1;
      if (runbist_select && run_cyc < 0) begin
        run_cyc = cyc;
        check_eq("run_entry", cyc - last_upd_cyc, 2);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (run_cyc >= 0 && stops && rs_cyc < 0 && cyc == run_cyc + stop_idx) begin
        reset_sm   = 1'b1;
        bist_error = (fail_idx >= 0);
        bist_data  = (fail_idx >= 0) ? 16'(fail_idx) : 16'hFFFF;
        rs_cyc     = cyc;
      end
      if (acc < n) begin
        cmd_valid = ($urandom_range(99) < vpct);
        cmd_cfg   = cmd_valid ? pc[acc] : 5'($urandom);
        cmd_chk   = cmd_valid ? pk[acc] : 5'($urandom);
        cmd_last  = cmd_valid ? (use_last && acc == n - 1) : 1'($urandom);
        if (cmd_ready && cmd_valid) acc++;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
    end

    cmd_valid = 1'b0;
    check_eq("done_seen", done_cyc >= 0, 1);
    if (done_cyc >= 0) begin
      if (stops) check_eq("done_latency", done_cyc - rs_cyc, 2);
      else       check_eq("timeout_latency", done_cyc - run_cyc, RT);
      check_eq("upd_count", upd, exp_n);
      check_eq("acc_count", acc, exp_n);
      check_eq("ready_after_load", ready_late, 0);
      check_eq("rep_pass", pass, exp_pass);
      check_eq("rep_timeout", timeout, !stops);
      check_eq("rep_fail_step", fail_step, exp_pass || !stops ? 16'hFFFF : 16'(fail_idx));
      check_eq("rep_runbist", runbist_select, 0);
    end
    quiet_engine();
    step();
    check_eq("post_done", {done, busy, bist_tlr}, 0);
    check_eq("post_pass_hold", pass, exp_pass);
  endtask

  initial begin
    TLR = 1'b1; start = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    cmd_cfg = '0; cmd_chk = '0;
    quiet_engine();
    step();
    step();
    check_reset_outputs("rst");
    TLR = 1'b0;
    step();
    check_eq("rst_release_tlr", bist_tlr, 0);

    run_prog(3, 1'b1, -1, 1'b0, 100);   // three-step pass
    run_prog(3, 1'b1, 2, 1'b0, 100);    // mismatch at step 2
    run_prog(3, 1'b1, -1, 1'b1, 100);   // run timeout
    run_prog(6, 1'b0, -1, 1'b0, 100);   // auto-stop at depth, no stop flag

    // Abort during LOAD.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("abort_in_load", cmd_ready, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_done", {done, busy, pass, timeout}, 4'b1100);
    check_eq("abort_fail_step", fail_step, 16'hFFFF);
    step();
    check_eq("abort_tlr", {bist_tlr, busy, done}, 3'b100);
    step();
    check_eq("abort_tlr_end", bist_tlr, 0);

    // Back-pressure with random programs.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(1) == 1)
        run_prog(int'($urandom_range(1, MS)), 1'b1, int'($urandom_range(0, 7)) - 3, 1'b0, 50);
      else
        run_prog(int'($urandom_range(MS, MS + 2)), 1'b0, int'($urandom_range(0, 7)) - 3, 1'b0, 40);
    end

    // Reset in RUN.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cmd_valid = 1'b1; cmd_cfg = 5'h0A; cmd_chk = 5'h15; cmd_last = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check_eq("pre_reset_run", runbist_select, 1);
    TLR = 1'b1;
    step();
    TLR = 1'b0;
    check_reset_outputs("run_rst");
    step();
    check_eq("run_rst_idle", {busy, bist_tlr}, 0);

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_idle", {busy, bist_tlr}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
